stack_sequencer: RTL and testbench

Multi-cycle control sequencer for the 16-bit stack CPU. It fetches the 18-bit instruction from the program ROM and decodes it, then drives every datapath strobe: IP write and IP-mux select, stack write/select, SP control, R/T write, T-input select, ALU op, carry write and jump-condition select. It also tracks stack depth, faults on overflow or underflow, supports halt and run gating, and counts retired instructions.

---
 rtl/stack_sequencer_if.sv | 41 ++++
 rtl/stack_sequencer.sv | 165 ++++++++++++++++
 tb/tb_stack_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
// Control bundle between the stack sequencer and the CPU datapath / program ROM.
// Bit vectors that carry instruction or condition data use ascending ranges so
// that bit 0 is the MSB, matching the instruction encoding.
interface stack_sequencer_if;
  logic        i_run;
  logic [0:17] i_instruction;
  logic [0:15] i_condVal;
  logic        i_carry;

  logic        o_ipW;
  logic        o_cond;
  logic        o_stkAddrSel;
  logic        o_stkW;
  logic        o_stkS;
  logic [2:0]  o_spCtrl;
  logic        o_RW;
  logic        o_RS;
  logic        o_TW;
  logic        o_TIn;
  logic        o_carryW;
  logic        o_instrTypeCtrl;
  logic [4:0]  o_instrOP;
  logic [1:0]  o_jSel;
  logic        o_halted;
  logic        o_fault;
  logic [15:0] o_retired;

  modport master (
    input  i_run, i_instruction, i_condVal, i_carry,
    output o_ipW, o_cond, o_stkAddrSel, o_stkW, o_stkS, o_spCtrl, o_RW, o_RS,
           o_TW, o_TIn, o_carryW, o_instrTypeCtrl, o_instrOP, o_jSel,
           o_halted, o_fault, o_retired
  );

  modport slave (
    output i_run, i_instruction, i_condVal, i_carry,
    input  o_ipW, o_cond, o_stkAddrSel, o_stkW, o_stkS, o_spCtrl, o_RW, o_RS,
           o_TW, o_TIn, o_carryW, o_instrTypeCtrl, o_instrOP, o_jSel,
           o_halted, o_fault, o_retired
  );
endinterface

// File: rtl/stack_sequencer.sv
// Three-cycle (FETCH/EXEC/WB) control sequencer for the 16-bit stack CPU.
// Strobes are Moore outputs of the state register and the latched opcode
// fields; stack depth is tracked here so overflow/underflow faults before EXEC.
module stack_sequencer #(
  parameter int STACK_DEPTH = 16
) (
  input logic               i_clock,
  input logic               i_reset_n,
  stack_sequencer_if.master bus
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT, FAULT} state_t;
  typedef enum logic [1:0] {CLS_ALU = 2'b00, CLS_LIT = 2'b01,
                            CLS_JMP = 2'b10, CLS_MISC = 2'b11} cls_t;

  localparam logic [2:0] SUB_PUSH = 3'b001;
  localparam logic [2:0] SUB_POP  = 3'b010;
  localparam logic [2:0] SUB_HALT = 3'b011;

  state_t        state, state_nxt;
  logic [0:6]    ir;        // class + op/jsel/cc/sub fields; literal bits go straight to T
  logic [DW-1:0] depth;
  logic          taken;
  logic [15:0]   retired;
  logic          cond_now;

  // Literal bits are consumed by the datapath directly, never by the sequencer.
  logic unused_literal;
  assign unused_literal = ^bus.i_instruction[7:17];

  // Decode of the latched instruction (used in EXEC/WB).
  cls_t ir_cls;
  logic ir_push, ir_pop, ir_halt;
  assign ir_cls  = cls_t'(ir[0:1]);
  assign ir_push = (ir_cls == CLS_MISC) && (ir[2:4] == SUB_PUSH);
  assign ir_pop  = (ir_cls == CLS_MISC) && (ir[2:4] == SUB_POP);
  assign ir_halt = (ir_cls == CLS_MISC) && (ir[2:4] == SUB_HALT);

  // Decode of the ROM word during FETCH, for the depth check.
  cls_t f_cls;
  logic f_push, f_pop;
  assign f_cls  = cls_t'(bus.i_instruction[0:1]);
  assign f_push = (f_cls == CLS_MISC) && (bus.i_instruction[2:4] == SUB_PUSH);
  assign f_pop  = (f_cls == CLS_MISC) && (bus.i_instruction[2:4] == SUB_POP);

  // Jump-condition evaluation from the live condition value and carry.
  always_comb begin
    case (ir[4:6])
      3'b000:  cond_now = 1'b1;
      3'b001:  cond_now = (bus.i_condVal == 16'h0000);
      3'b010:  cond_now = (bus.i_condVal != 16'h0000);
      3'b011:  cond_now = bus.i_condVal[0];
      3'b100:  cond_now = !bus.i_condVal[0];
      3'b101:  cond_now = bus.i_carry;
      3'b110:  cond_now = !bus.i_carry;
      default: cond_now = 1'b0;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of process ordering.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Instruction register, jump flag, stack depth and retired counter.
  // NOTE: the IR is reset along with the control state so decode never sees X
  // after reset; it is a single register, not a memory array.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ir      <= '0;
      taken   <= 1'b0;
      depth   <= '0;
      retired <= '0;
    end else begin
      case (state)
        FETCH: ir <= bus.i_instruction[0:6];
        EXEC: begin
          if (ir_cls == CLS_JMP) taken <= cond_now;
          if (ir_push)           depth <= depth + DW'(1);
          else if (ir_pop)       depth <= depth - DW'(1);
        end
        WB:      retired <= retired + 16'd1;
        default: ;
      endcase
    end
  end

  // Next-state and Moore strobe decode.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt            = state;
    bus.o_ipW            = 1'b0;
    bus.o_cond           = 1'b0;
    bus.o_stkW           = 1'b0;
    bus.o_stkS           = 1'b0;
    bus.o_spCtrl         = 3'b000;
    bus.o_RW             = 1'b0;
    bus.o_RS             = 1'b0;
    bus.o_TW             = 1'b0;
    bus.o_TIn            = 1'b0;
    bus.o_carryW         = 1'b0;
    bus.o_instrTypeCtrl  = 1'b1;
    bus.o_instrOP        = 5'b00000;
    bus.o_jSel           = 2'b00;
    bus.o_halted         = 1'b0;
    bus.o_fault          = 1'b0;
    case (state)
      IDLE: if (bus.i_run) state_nxt = FETCH;
      FETCH: begin
        if ((f_cls == CLS_ALU && depth == '0) ||
            (f_pop && depth == '0) ||
            (f_push && depth == DW'(STACK_DEPTH)))
          state_nxt = FAULT;
        else
          state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = ir_halt ? HALT : WB;
        case (ir_cls)
          CLS_ALU: begin
            bus.o_instrTypeCtrl = 1'b0;
            bus.o_instrOP       = ir[2:6];
            bus.o_RW            = 1'b1;
            bus.o_carryW        = 1'b1;
          end
          CLS_LIT: begin
            bus.o_TIn = 1'b1;
            bus.o_TW  = 1'b1;
          end
          CLS_JMP: bus.o_jSel = ir[2:3];
          default: begin
            if (ir_push) begin
              bus.o_RS     = 1'b1;
              bus.o_stkW   = 1'b1;
              bus.o_spCtrl = 3'b010;
            end else if (ir_pop) begin
              bus.o_stkS   = 1'b1;
              bus.o_TW     = 1'b1;
              bus.o_spCtrl = 3'b001;
            end
          end
        endcase
      end
      WB: begin
        bus.o_ipW  = 1'b1;
        bus.o_cond = (ir_cls == CLS_JMP) && taken;
        if (ir_cls == CLS_ALU) begin
          bus.o_RS   = 1'b1;
          bus.o_stkW = 1'b1;
        end
        state_nxt = bus.i_run ? FETCH : IDLE;
      end
      HALT:    bus.o_halted = 1'b1;
      FAULT:   bus.o_fault  = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_stkAddrSel = 1'b0;
  assign bus.o_retired    = retired;
endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: cadence, per-class strobes, jump
// conditions, depth faults, halt, run drop and asynchronous reset.
module tb_stack_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   pulses;

  localparam logic [0:17] NOP_I  = {2'b11, 3'b000, 13'd0};
  localparam logic [0:17] PUSH_I = {2'b11, 3'b001, 13'd0};
  localparam logic [0:17] POP_I  = {2'b11, 3'b010, 13'd0};
  localparam logic [0:17] HALT_I = {2'b11, 3'b011, 13'd0};
  localparam logic [0:17] LIT_I  = {2'b01, 16'h0005};
  localparam logic [0:17] ALU_I  = {2'b00, 5'b01001, 11'd0};

  stack_sequencer_if bus ();

  stack_sequencer #(.STACK_DEPTH(16)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [0:17] jmp(input logic [1:0] jsel, input logic [2:0] cc);
    return {2'b10, jsel, cc, 11'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // From a FETCH cycle: present the instruction and advance into EXEC.
  task automatic to_exec(input logic [0:17] instr);
    bus.i_instruction = instr;
    tick();
  endtask

  // One jump instruction: checks o_jSel in EXEC and o_cond in WB.
  task automatic do_jmp(input string tag, input logic [1:0] jsel, input logic [2:0] cc,
                        input logic [15:0] cv, input logic cy, input logic exp_cond);
    bus.i_condVal = cv;
    bus.i_carry   = cy;
    to_exec(jmp(jsel, cc));
    check({tag, "_jsel"}, {30'd0, bus.o_jSel}, {30'd0, jsel});
    tick();
    check({tag, "_cond"}, {31'd0, bus.o_cond}, {31'd0, exp_cond});
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.i_run         = 1'b0;
    bus.i_instruction = NOP_I;
    bus.i_condVal     = 16'h0000;
    bus.i_carry       = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    check("rst_ipw",     {31'd0, bus.o_ipW},            32'd0);
    check("rst_itc",     {31'd0, bus.o_instrTypeCtrl},  32'd1);
    check("rst_op",      {27'd0, bus.o_instrOP},        32'd0);
    check("rst_retired", {16'd0, bus.o_retired},        32'd0);
    check("rst_fault",   {30'd0, bus.o_fault, bus.o_halted}, 32'd0);

    // Cadence: IDLE one cycle, then FETCH/EXEC/WB
    bus.i_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("idle_ipw", {31'd0, bus.o_ipW}, 32'd0);
    tick();
    check("fetch_ipw", {31'd0, bus.o_ipW}, 32'd0);
    tick();
    check("exec_ipw", {31'd0, bus.o_ipW}, 32'd0);
    tick();
    check("wb_ipw", {31'd0, bus.o_ipW}, 32'd1);
    check("wb_retired", {16'd0, bus.o_retired}, 32'd0);
    tick();
    check("fetch2_ipw", {31'd0, bus.o_ipW}, 32'd0);
    check("retired_1", {16'd0, bus.o_retired}, 32'd1);

    // LIT 0x0005
    to_exec(LIT_I);
    check("lit_tin", {31'd0, bus.o_TIn}, 32'd1);
    check("lit_tw",  {31'd0, bus.o_TW},  32'd1);
    tick();
    tick();
    // PUSH
    to_exec(PUSH_I);
    check("push_sp",  {29'd0, bus.o_spCtrl}, 32'b010);
    check("push_stk", {30'd0, bus.o_RS, bus.o_stkW}, 32'b11);
    tick();
    tick();
    // ALU op 01001
    to_exec(ALU_I);
    check("alu_op",  {27'd0, bus.o_instrOP}, 32'b01001);
    check("alu_itc", {31'd0, bus.o_instrTypeCtrl}, 32'd0);
    check("alu_rw_cw", {30'd0, bus.o_RW, bus.o_carryW}, 32'b11);
    tick();
    check("alu_wb_stkw", {31'd0, bus.o_stkW}, 32'd1);
    check("alu_wb_rs",   {31'd0, bus.o_RS}, 32'd1);
    check("alu_wb_itc",  {31'd0, bus.o_instrTypeCtrl}, 32'd1);
    tick();
    check("retired_4", {16'd0, bus.o_retired}, 32'd4);

    // Jumps
    do_jmp("jz_zero",  2'b10, 3'b001, 16'h0000, 1'b0, 1'b1);
    do_jmp("jz_nz",    2'b10, 3'b001, 16'h8000, 1'b0, 1'b0);
    do_jmp("js_neg",   2'b01, 3'b011, 16'h8000, 1'b0, 1'b1);
    do_jmp("jnever",   2'b11, 3'b111, 16'h0000, 1'b1, 1'b0);
    do_jmp("jcarry",   2'b00, 3'b101, 16'h1234, 1'b1, 1'b1);
    check("retired_9", {16'd0, bus.o_retired}, 32'd9);

    // POP to depth 0, then ALU at depth 0 faults
    to_exec(POP_I);
    check("pop_sp",   {29'd0, bus.o_spCtrl}, 32'b001);
    check("pop_bus",  {29'd0, bus.o_stkS, bus.o_TW, bus.o_TIn}, 32'b110);
    tick();
    tick();
    check("retired_10", {16'd0, bus.o_retired}, 32'd10);
    to_exec(ALU_I);
    check("alu_uf_fault", {31'd0, bus.o_fault}, 32'd1);
    check("alu_uf_strobes", {29'd0, bus.o_ipW, bus.o_RW, bus.o_carryW}, 32'd0);
    tick();
    check("alu_uf_sticky", {31'd0, bus.o_fault}, 32'd1);
    check("alu_uf_retired", {16'd0, bus.o_retired}, 32'd10);

    // Asynchronous reset clears fault without a clock edge
    #2 rst_n = 1'b0;
    #1 check("async_fault_clr", {31'd0, bus.o_fault}, 32'd0);
    check("async_retired_clr", {16'd0, bus.o_retired}, 32'd0);

    // 16 PUSHes succeed, the 17th faults from FETCH
    @(negedge clk);
    bus.i_instruction = PUSH_I;
    rst_n = 1'b1;
    tick();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      tick();
      if (bus.o_ipW) pulses++;
      tick();
    end
    check("push16_pulses", pulses, 32'd16);
    check("push16_retired", {16'd0, bus.o_retired}, 32'd16);
    tick();
    check("push17_fault", {31'd0, bus.o_fault}, 32'd1);
    check("push17_ipw",   {31'd0, bus.o_ipW}, 32'd0);
    check("push17_sp",    {29'd0, bus.o_spCtrl}, 32'd0);
    tick();
    check("push17_retired", {16'd0, bus.o_retired}, 32'd16);

    // POP at depth 0 faults from FETCH
    bus.i_instruction = POP_I;
    do_reset();
    tick();
    tick();
    check("pop_uf_fault", {31'd0, bus.o_fault}, 32'd1);
    check("pop_uf_stks",  {31'd0, bus.o_stkS}, 32'd0);

    // i_run dropped mid-instruction: completes, then IDLE
    bus.i_instruction = NOP_I;
    do_reset();
    tick();
    bus.i_run = 1'b0;
    tick();
    tick();
    check("rundrop_wb", {31'd0, bus.o_ipW}, 32'd1);
    tick();
    check("rundrop_idle", {31'd0, bus.o_ipW}, 32'd0);
    tick();
    tick();
    tick();
    check("rundrop_hold", {31'd0, bus.o_ipW}, 32'd0);
    check("rundrop_retired", {16'd0, bus.o_retired}, 32'd1);

    // HALT
    bus.i_instruction = HALT_I;
    bus.i_run = 1'b1;
    tick();
    tick();
    check("halt_exec", {30'd0, bus.o_halted, bus.o_ipW}, 32'd0);
    tick();
    check("halt_state", {31'd0, bus.o_halted}, 32'd1);
    tick();
    check("halt_sticky", {30'd0, bus.o_halted, bus.o_ipW}, 32'b10);
    check("halt_retired", {16'd0, bus.o_retired}, 32'd1);

    // Reset asserted mid-EXEC of a LIT clears outputs immediately
    bus.i_instruction = LIT_I;
    do_reset();
    tick();
    tick();
    check("lit2_tw", {31'd0, bus.o_TW}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("midexec_tw_tin", {30'd0, bus.o_TW, bus.o_TIn}, 32'd0);
    check("midexec_itc", {31'd0, bus.o_instrTypeCtrl}, 32'd1);
    check("midexec_halted", {31'd0, bus.o_halted}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
